load_enable_ctrl: RTL and testbench

- Control front-end that drives the Load and Enable inputs of the 4-bit decade down-counter stage.
- Conditions two raw board inputs, a load push-button and a run switch, by synchronising and debouncing them.
- Produces a prescaled one-cycle Enable tick stream while running, and a single Load pulse per button press.
- Every Load pulse is issued together with an Enable pulse, so the downstream counter loads 10 on the same edge.

---
 rtl/lab_ctrl_pkg.sv | 18 +
 rtl/sync_debounce.sv | 42 ++++
 rtl/load_enable_ctrl.sv | 100 ++++++++++
 tb/tb_load_enable_ctrl.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/lab_ctrl_pkg.sv
// Shared types and defaults for the decade-counter load/enable front-end.
package lab_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PEND = 2'd1,
    FIRE = 2'd2,
    HOLD = 2'd3
  } load_st_e;

  localparam int DIV_DEF         = 4;
  localparam int DB_CYCLES_DEF   = 8;
  localparam int SYNC_STAGES_DEF = 2;

  // Value the downstream decade counter takes when Load and Enable coincide
  localparam logic [3:0] CNT_LOAD_VAL = 4'd10;

endpackage

// File: rtl/sync_debounce.sv
// Multi-flop synchroniser followed by a saturating-agreement debouncer.
module sync_debounce #(
  parameter int SYNC_STAGES = 2,
  parameter int DB_CYCLES   = 8
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_raw,
  output logic o_level
);

  localparam int            CW       = $clog2(DB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0]          r_cnt;
  logic                   r_level;
  logic                   w_sync;

  assign w_sync  = r_sync[SYNC_STAGES-1];
  assign o_level = r_level;

  // The level flips on the DB_CYCLES-th consecutive disagreeing sample
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync  <= '0;
      r_cnt   <= '0;
      r_level <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      if (w_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_level <= w_sync;
        r_cnt   <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/load_enable_ctrl.sv
// Load/Enable front-end for the decade down-counter: debounced inputs,
// prescaled Enable ticks, one Load per press. `STEP_MODE_EN adds Step_btn.
module load_enable_ctrl
  import lab_ctrl_pkg::*;
#(
  parameter int DIV         = DIV_DEF,
  parameter int DB_CYCLES   = DB_CYCLES_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic clk,
  input  logic Clear_n,
  input  logic Load_btn,
  input  logic Run_sw,
`ifdef STEP_MODE_EN
  input  logic Step_btn,
`endif
  output logic Enable,
  output logic Load,
  output logic Load_pend
);

  localparam int            PW       = $clog2(DIV);
  localparam logic [PW-1:0] PRE_TERM = PW'(DIV - 1);

  logic          w_load_db;
  logic          w_run_db;
  logic          w_step;
  logic          w_tick;
  logic          w_fire_nxt;
  load_st_e      r_state;
  load_st_e      w_state_nxt;
  logic [PW-1:0] r_pre;
  logic          r_load_q;
  logic          r_en;
  logic          r_load;

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_load_db (
    .i_clk(clk), .i_rst_n(Clear_n), .i_raw(Load_btn), .o_level(w_load_db)
  );

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_run_db (
    .i_clk(clk), .i_rst_n(Clear_n), .i_raw(Run_sw), .o_level(w_run_db)
  );

`ifdef STEP_MODE_EN
  logic w_step_db;
  logic r_step_q;

  sync_debounce #(.SYNC_STAGES(SYNC_STAGES), .DB_CYCLES(DB_CYCLES)) u_step_db (
    .i_clk(clk), .i_rst_n(Clear_n), .i_raw(Step_btn), .o_level(w_step_db)
  );

  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) r_step_q <= 1'b0;
    else          r_step_q <= w_step_db;
  end

  // Steps only count while stopped; a step landing on FIRE merges into its Enable
  assign w_step = w_step_db & ~r_step_q & ~w_run_db;
`else
  assign w_step = 1'b0;
`endif

  assign w_tick     = w_run_db && (r_pre == PRE_TERM);
  assign w_fire_nxt = (r_state == PEND);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_load_db && !r_load_q) w_state_nxt = PEND;
      PEND:    w_state_nxt = FIRE;
      FIRE:    w_state_nxt = HOLD;
      HOLD:    if (!w_load_db) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // FIRE restarts the prescaler so the next tick is a full DIV cycles away
  always_ff @(posedge clk or negedge Clear_n) begin
    if (!Clear_n) begin
      r_state  <= IDLE;
      r_pre    <= '0;
      r_load_q <= 1'b0;
      r_en     <= 1'b0;
      r_load   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_load_q <= w_load_db;
      r_load   <= w_fire_nxt;
      r_en     <= w_fire_nxt | w_tick | w_step;
      if (w_fire_nxt || !w_run_db || w_tick) r_pre <= '0;
      else                                   r_pre <= r_pre + PW'(1);
    end
  end

  assign Enable    = r_en;
  assign Load      = r_load;
  assign Load_pend = (r_state == PEND);

endmodule

// File: tb/tb_load_enable_ctrl.sv
// Directed bench for load_enable_ctrl: vector table plus corner-case sequences.
module tb_load_enable_ctrl;

  logic clk       = 1'b0;
  logic Clear_n   = 1'b0;
  logic Load_btn  = 1'b0;
  logic Run_sw    = 1'b0;
`ifdef STEP_MODE_EN
  logic Step_btn  = 1'b0;
`endif
  logic Enable, Load, Load_pend;

  int n_tests = 0;
  int n_fail  = 0;
  int mcnt    = 0;

  load_enable_ctrl #(.DIV(4), .DB_CYCLES(8), .SYNC_STAGES(2)) dut (
    .clk      (clk),
    .Clear_n  (Clear_n),
    .Load_btn (Load_btn),
    .Run_sw   (Run_sw),
`ifdef STEP_MODE_EN
    .Step_btn (Step_btn),
`endif
    .Enable   (Enable),
    .Load     (Load),
    .Load_pend(Load_pend)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic clr;
    logic ld;
    logic run;
    int   n;
    logic en;
    logic lo;
    logic pd;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic clr, input logic ld, input logic run, input int n,
                     input logic en, input logic lo, input logic pd);
    vec_t v;
    v.clr = clr; v.ld = ld; v.run = run; v.n = n;
    v.en = en; v.lo = lo; v.pd = pd;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One clock, sampled 1ns after the edge; downstream decade counter model
  task automatic cyc();
    @(posedge clk);
    #1;
    if (Enable === 1'b1) mcnt = (Load === 1'b1) ? 10 : ((mcnt == 0) ? 9 : mcnt - 1);
  endtask

  task automatic collide(input int off, output int lat);
    int t;
    int a;
    logic exp_en;
    t = 0;
    while (t < 40) begin
      cyc();
      if (Enable === 1'b1) break;
      t++;
    end
    lat = t;
    chk("coll_tick_seen", (t < 40), 1);
    repeat (off) cyc();
    Load_btn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      cyc();
      a = off + 1 + k;
      exp_en = (a == off + 12) ||
               (a < off + 12 && a % 4 == 0) ||
               (a > off + 12 && (a - off - 12) % 4 == 0);
      chk($sformatf("coll%0d_en_a%0d", off, a), Enable, exp_en);
      chk($sformatf("coll%0d_ld_a%0d", off, a), Load, (a == off + 12));
      chk($sformatf("coll%0d_pd_a%0d", off, a), Load_pend, (a == off + 11));
      if (a == off + 12) chk($sformatf("coll%0d_cnt10", off), mcnt, 10);
      if (a == off + 16) chk($sformatf("coll%0d_cnt9", off), mcnt, 9);
    end
    Load_btn = 1'b0;
    repeat (15) cyc();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int lat;

    // clr ld run  n   en lo pd
    add(0, 1, 1,  3,  0, 0, 0);   // reset held, inputs toggling
    add(0, 0, 0,  3,  0, 0, 0);
    add(0, 1, 0,  3,  0, 0, 0);
    add(1, 0, 0, 20,  0, 0, 0);   // released, stopped: no ticks
    add(1, 1, 0, 10,  0, 0, 0);   // press: edges 0..9 quiet
    add(1, 1, 0,  1,  0, 0, 1);   // edge 10: pending
    add(1, 1, 0,  1,  1, 1, 0);   // edge 11: Load with Enable
    add(1, 1, 0, 28,  0, 0, 0);   // held button: no repeat
    add(1, 0, 0, 20,  0, 0, 0);
    for (int r = 0; r < 5; r++) begin
      add(1, 1, 0, 3, 0, 0, 0);   // 3-cycle bounce
      add(1, 0, 0, 3, 0, 0, 0);
    end
    add(1, 0, 0, 20,  0, 0, 0);
    add(1, 0, 1,  7,  0, 0, 0);   // 7-cycle run glitch
    add(1, 0, 0, 20,  0, 0, 0);

    for (int i = 0; i < tbl.size(); i++) begin
      Clear_n  = tbl[i].clr;
      Load_btn = tbl[i].ld;
      Run_sw   = tbl[i].run;
      for (int j = 0; j < tbl[i].n; j++) begin
        cyc();
        chk($sformatf("vec%0d_c%0d_en", i, j), Enable, tbl[i].en);
        chk($sformatf("vec%0d_c%0d_ld", i, j), Load, tbl[i].lo);
        chk($sformatf("vec%0d_c%0d_pd", i, j), Load_pend, tbl[i].pd);
      end
    end
    chk("press_model_cnt", mcnt, 10);

    // Run: first tick after edge 13, then every 4th cycle
    Run_sw = 1'b1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      chk($sformatf("run_en_k%0d", k), Enable, (k >= 13 && (k - 13) % 4 == 0));
    end
    Run_sw = 1'b0;
    repeat (12) cyc();
    for (int k = 0; k < 20; k++) begin
      cyc();
      chk($sformatf("run_stop_k%0d", k), Enable, 1'b0);
    end

    // Resume (prescaler restarted from 0), then FIRE on / off a terminal count
    Run_sw = 1'b1;
    collide(0, lat);
    chk("resume_latency", lat, 13);
    collide(2, lat);
    Run_sw = 1'b0;
    repeat (25) cyc();

    // Reset while pending discards the load
    Load_btn = 1'b1;
    repeat (11) cyc();
    chk("midrst_pend", Load_pend, 1'b1);
    Clear_n  = 1'b0;
    Load_btn = 1'b0;
    #1;
    chk("midrst_pend_clr", Load_pend, 1'b0);
    chk("midrst_en_clr", Enable, 1'b0);
    cyc();
    Clear_n = 1'b1;
    for (int k = 0; k < 30; k++) begin
      cyc();
      chk($sformatf("midrst_noload_k%0d", k), Load, 1'b0);
      chk($sformatf("midrst_noen_k%0d", k), Enable, 1'b0);
    end

`ifdef STEP_MODE_EN
    Load_btn = 1'b1;
    repeat (15) cyc();
    Load_btn = 1'b0;
    repeat (15) cyc();
    chk("step_preload", mcnt, 10);
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 24; k++) begin
        Step_btn = (k < 12);
        cyc();
        chk($sformatf("step%0d_en_k%0d", p, k), Enable, (k == 10));
        chk($sformatf("step%0d_ld_k%0d", p, k), Load, 1'b0);
      end
      chk($sformatf("step%0d_cnt", p), mcnt, 9 - p);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
